clk_period_meter: RTL

- Measures a slow, divider-generated clock or square wave (sig_in) against the system clock and reports period and high time in system-clock cycles.
- Sits on the consumer side of the clock-divider output. Used for self-check of divided clocks and as a generic slow-pulse timing front end.
- sig_in is treated as asynchronous: 2-flop synchronizer, then edge detection, FSM and counters.

---
 rtl/clk_period_meter_pkg.sv | 13 +
 rtl/clk_period_meter_sync_edge_det.sv | 32 +++
 rtl/clk_period_meter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and default sizing.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF   = 20;
  localparam int unsigned TIMEOUT_DEF = 100000;

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus an edge register; gives the synchronized level and
// single-cycle rise/fall strobes two clocks after the input changes.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in system-clock
// cycles, single-shot or free-running, with a timeout on missing edges.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic sig_level_unused;
  logic sig_rise;
  logic sig_fall;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sig_in),
    .level_o (sig_level_unused),
    .rise_o  (sig_rise),
    .fall_o  (sig_fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic             hi_seen_q;
  logic             cont_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             valid_q;
  logic             timeout_q;

  // cnt restarts at 1 on the rise that opens a period, so the next rise and the
  // first fall sample exactly the number of clocks elapsed since that rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      hi_seen_q   <= 1'b0;
      cont_q      <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            cont_q  <= cont;
          end
        end
        ST_ARM: begin
          if (sig_rise) begin
            state_q   <= ST_MEASURE;
            cnt_q     <= ONE_C;
            hi_cnt_q  <= '0;
            hi_seen_q <= 1'b0;
          end else if (cnt_q == TIMEOUT_C) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        ST_MEASURE: begin
          if (sig_rise) begin
            period_q    <= cnt_q;
            high_time_q <= hi_cnt_q;
            valid_q     <= 1'b1;
            cnt_q       <= ONE_C;
            hi_cnt_q    <= '0;
            hi_seen_q   <= 1'b0;
            if (!cont_q) begin
              state_q <= ST_IDLE;
            end
          end else begin
            if (cnt_q == TIMEOUT_C) begin
              timeout_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
            if (sig_fall && !hi_seen_q) begin
              hi_cnt_q  <= cnt_q;
              hi_seen_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
